// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared control constants for the PC redirect controller: PC select codes,
// FSM state encoding and the hard-wired zero register index.
package cpu_ctrl_pkg;

  localparam logic [1:0] PC_SEL_PC4 = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_JR  = 2'b10;
  localparam logic [1:0] PC_SEL_JAL = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALL,
    ST_FLUSH
  } ctrl_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// EX/ID resolution inputs and PC/pipeline-register control outputs of the
// redirect controller, bundled as one interface.
interface pc_redirect_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic             ex_valid;
  logic             ex_branch;
  logic             ex_br_taken;
  logic             ex_jr;
  logic             ex_jal;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             mem_stall;
  logic [1:0]       pc_sel;
  logic             pc_en;
  logic             flush;
  logic             if_id_kill;
  logic             if_id_hold;
  logic             id_ex_bubble;
  logic [CNT_W-1:0] redirect_count;

  modport master (
    output ex_valid, ex_branch, ex_br_taken, ex_jr, ex_jal, ex_mem_read, ex_rd,
           id_rs, id_rt, id_uses_rs, id_uses_rt, mem_stall,
    input  pc_sel, pc_en, flush, if_id_kill, if_id_hold, id_ex_bubble, redirect_count
  );

  modport slave (
    input  ex_valid, ex_branch, ex_br_taken, ex_jr, ex_jal, ex_mem_read, ex_rd,
           id_rs, id_rt, id_uses_rs, id_uses_rt, mem_stall,
    output pc_sel, pc_en, flush, if_id_kill, if_id_hold, id_ex_bubble, redirect_count
  );
endinterface

// File: rtl/pc_redirect_ctrl_hazard_detect.sv
// Combinational load-use hazard comparator between the EX load destination
// and the ID source operands.
module hazard_detect
  import cpu_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  output logic       load_use
);

  always_comb begin
    load_use = ex_valid & ex_mem_read & (ex_rd != REG_ZERO) &
               ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC redirect controller: sequences branch/jump redirects, load-use stalls
// and the wrong-path squash window; counts redirects taken.
module pc_redirect_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             CLK,
  input  logic             RST,
  pc_redirect_ctrl_if.slave bus
);

  localparam logic [1:0]  FLUSH_INIT    = 2'(FLUSH_CYCLES - 1);
  localparam ctrl_state_e REDIRECT_NEXT = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;

  ctrl_state_e      state, next_state;
  logic [1:0]       flush_cnt;
  logic [CNT_W-1:0] count;
  logic             load_use;
  logic             redirect;
  logic [1:0]       redirect_sel;
  logic             cnt_load, cnt_dec, count_inc;

  hazard_detect u_hazard (
    .ex_valid    (bus.ex_valid),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rd       (bus.ex_rd),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rs  (bus.id_uses_rs),
    .id_uses_rt  (bus.id_uses_rt),
    .load_use    (load_use)
  );

  always_comb begin
    redirect = bus.ex_valid &
               ((bus.ex_branch & bus.ex_br_taken) | bus.ex_jr | bus.ex_jal);
    if (bus.ex_jal)     redirect_sel = PC_SEL_JAL;
    else if (bus.ex_jr) redirect_sel = PC_SEL_JR;
    else                redirect_sel = PC_SEL_BR;
  end

  // Reset forces the idle output pattern combinationally, so a reset
  // mid-flush or mid-stall drops the strobes in the same cycle.
  always_comb begin
    next_state       = state;
    bus.pc_sel       = PC_SEL_PC4;
    bus.pc_en        = 1'b1;
    bus.flush        = 1'b0;
    bus.if_id_kill   = 1'b0;
    bus.if_id_hold   = 1'b0;
    bus.id_ex_bubble = 1'b0;
    cnt_load         = 1'b0;
    cnt_dec          = 1'b0;
    count_inc        = 1'b0;
    if (!RST) begin
      unique case (state)
        ST_RUN: begin
          if (bus.mem_stall) begin
            bus.pc_en      = 1'b0;
            bus.if_id_hold = 1'b1;
          end else if (redirect) begin
            bus.pc_sel       = redirect_sel;
            bus.flush        = 1'b1;
            bus.if_id_kill   = 1'b1;
            bus.id_ex_bubble = 1'b1;
            cnt_load         = 1'b1;
            count_inc        = 1'b1;
            next_state       = REDIRECT_NEXT;
          end else if (load_use) begin
            bus.pc_en        = 1'b0;
            bus.if_id_hold   = 1'b1;
            bus.id_ex_bubble = 1'b1;
            next_state       = ST_STALL;
          end
        end
        ST_STALL: begin
          if (bus.mem_stall) begin
            bus.pc_en      = 1'b0;
            bus.if_id_hold = 1'b1;
          end else begin
            next_state = ST_RUN;
          end
        end
        ST_FLUSH: begin
          bus.if_id_kill   = 1'b1;
          bus.id_ex_bubble = 1'b1;
          if (bus.mem_stall) begin
            bus.pc_en = 1'b0;
          end else begin
            cnt_dec = 1'b1;
            if (flush_cnt == 2'd1) next_state = ST_RUN;
          end
        end
        default: next_state = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_RUN;
      flush_cnt <= '0;
      count     <= '0;
    end else begin
      state <= next_state;
      if (cnt_load)     flush_cnt <= FLUSH_INIT;
      else if (cnt_dec) flush_cnt <= flush_cnt - 2'd1;
      if (count_inc)    count <= count + CNT_W'(1);
    end
  end

  assign bus.redirect_count = count;

endmodule
